// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default frame parameters
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO; a pop never frees space for a same-cycle push
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with runtime parity and stop-bit selection
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_pulse,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          s_valid,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          tx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 bit_end, last_stop, start_frame;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (start_frame),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bit_end     = (state_q != IDLE) && baud_pulse && (tick_q == TICK_LAST);
    assign last_stop   = (state_q == STOP) && bit_end && (stop_q || !stop2_q);
    // Back-to-back frames pop straight out of the final stop tick, skipping IDLE.
    assign start_frame = !fifo_empty && ((state_q == IDLE) || last_stop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;

        if (state_q == IDLE || bit_end) tick_d = '0;
        else if (baud_pulse)            tick_d = tick_q + 1'b1;

        case (state_q)
            IDLE: ;
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                stop_d  = 1'b0;
            end
            STOP: if (bit_end) begin
                if (last_stop) state_d = IDLE;
                else           stop_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Config is sampled only here, so mid-frame changes apply to the next frame.
        if (start_frame) begin
            state_d   = START;
            tick_d    = '0;
            bit_d     = '0;
            stop_d    = 1'b0;
            shift_d   = fifo_data;
            par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit_d = (cfg_parity == PAR_ODD) ? ~^fifo_data : ^fifo_data;
            stop2_d   = cfg_stop2;
        end
    end

    always_comb begin
        tx_d   = 1'b1;
        done_d = last_stop;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign busy    = (state_q != IDLE) || done_q;
    assign s_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [3:0] fifo_level;
    logic       busy;
    logic       tx_done;
    logic       tx;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .baud_pulse (baud_pulse),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       stop2;
        logic       has_par;
        logic       par_bit;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_bit(int k, logic [7:0] d, logic hp, logic pb);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (hp && k == 9) return pb;
        return 1'b1;
    endfunction

    // Current negedge sample is bit 0, cycle 0; returns on the last cycle of the last stop bit.
    task automatic check_frame(input logic [7:0] d, input logic hp, input logic pb,
                               input logic st2, input string nm);
        int nb;
        int ctl_bad;
        logic e;
        logic [31:0] act;
        nb = 10 + int'(hp) + int'(st2);
        ctl_bad = 0;
        for (int k = 0; k < nb; k++) begin
            e = exp_bit(k, d, hp, pb);
            act = {31'b0, e};
            for (int c = 0; c < 16; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (tx !== e && act == {31'b0, e}) act = {31'b0, tx};
                if (tx_done !== ((k == nb - 1) && (c == 15)) || busy !== 1'b1) ctl_bad++;
            end
            chk($sformatf("%s bit%0d", nm, k), act, {31'b0, e});
        end
        chk($sformatf("%s done/busy", nm), ctl_bad, 0);
    endtask

    task automatic check_idle(input string nm);
        chk($sformatf("%s idle busy", nm), {31'b0, busy}, 0);
        chk($sformatf("%s idle tx_done", nm), {31'b0, tx_done}, 0);
        chk($sformatf("%s idle tx", nm), {31'b0, tx}, 1);
        chk($sformatf("%s idle level", nm), {28'b0, fifo_level}, 0);
    endtask

    task automatic wait_tx_low(output int cnt);
        cnt = 0;
        while (tx !== 1'b0 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int bad;
        vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 2'b01, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'h07, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 2'b11, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 2'b10, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        baud_pulse = 1'b1;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset tx", {31'b0, tx}, 1);
        chk("reset tx_done", {31'b0, tx_done}, 0);
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset level", {28'b0, fifo_level}, 0);
        chk("reset s_ready", {31'b0, s_ready}, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            cfg_parity = vecs[i].par;
            cfg_stop2 = vecs[i].stop2;
            s_data = vecs[i].data;
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            wait_tx_low(cnt);
            chk($sformatf("vec%0d latency", i), cnt, 2);
            check_frame(vecs[i].data, vecs[i].has_par, vecs[i].par_bit, vecs[i].stop2,
                        $sformatf("vec%0d", i));
            @(negedge clk);
            check_idle($sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // Three frames back to back
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h11;
        @(negedge clk);
        s_data = 8'h22;
        @(negedge clk);
        s_data = 8'h33;
        @(negedge clk);
        s_valid = 1'b0;
        wait_tx_low(cnt);
        chk("b2b start", {31'b0, tx}, 0);
        check_frame(8'h11, 1'b0, 1'b0, 1'b0, "b2b f1");
        @(negedge clk);
        check_frame(8'h22, 1'b0, 1'b0, 1'b0, "b2b f2");
        @(negedge clk);
        check_frame(8'h33, 1'b0, 1'b0, 1'b0, "b2b f3");
        @(negedge clk);
        check_idle("b2b");
        repeat (3) @(negedge clk);

        // Fill the FIFO while the line is stalled in a START bit
        baud_pulse = 1'b0;
        s_data = 8'h5A;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall tx", {31'b0, tx}, 0);
        chk("stall busy", {31'b0, busy}, 1);
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 8'h41 + 8'(i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("full level", {28'b0, fifo_level}, 8);
        chk("full s_ready", {31'b0, s_ready}, 0);
        baud_pulse = 1'b1;
        @(negedge clk);
        check_frame(8'h5A, 1'b0, 1'b0, 1'b0, "stall f0");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_frame(8'h41 + 8'(i), 1'b0, 1'b0, 1'b0, $sformatf("fifo w%0d", i + 1));
        end
        @(negedge clk);
        check_idle("fifo");
        repeat (3) @(negedge clk);

        // Parity change during frame 1 affects only frame 2
        s_valid = 1'b1;
        s_data = 8'h55;
        @(negedge clk);
        s_data = 8'h07;
        @(negedge clk);
        s_valid = 1'b0;
        wait_tx_low(cnt);
        fork
            check_frame(8'h55, 1'b0, 1'b0, 1'b0, "cfg f1");
            begin
                repeat (40) @(negedge clk);
                cfg_parity = 2'b10;
            end
        join
        @(negedge clk);
        check_frame(8'h07, 1'b1, 1'b0, 1'b0, "cfg f2");
        @(negedge clk);
        check_idle("cfg");
        cfg_parity = 2'b00;
        repeat (3) @(negedge clk);

        // Reset in the middle of DATA with three words queued
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = (i == 0) ? 8'h00 : 8'h80 + 8'(i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        wait_tx_low(cnt);
        repeat (40) @(negedge clk);
        chk("pre-rst level", {28'b0, fifo_level}, 3);
        chk("pre-rst tx", {31'b0, tx}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst tx", {31'b0, tx}, 1);
        chk("rst busy", {31'b0, busy}, 0);
        chk("rst level", {28'b0, fifo_level}, 0);
        chk("rst tx_done", {31'b0, tx_done}, 0);
        chk("rst s_ready", {31'b0, s_ready}, 1);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("post-rst quiet", bad, 0);
        s_data = 8'hC3;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        wait_tx_low(cnt);
        chk("post-rst latency", cnt, 2);
        check_frame(8'hC3, 1'b0, 1'b0, 1'b0, "post-rst");
        @(negedge clk);
        check_idle("post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
